// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the IF/ID/EX hazard controller.
// Sequencer states and EX operand forwarding selects.
package hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LD_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    FLUSH    = 2'b11
  } hzd_state_t;

  typedef enum logic [1:0] {
    no_fwd  = 2'b00,
    ex_fwd  = 2'b01,
    mem_fwd = 2'b10
  } fwdmux_sel_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stage controls out.
// HAZARD_PERF_CNT_EN adds the stall/flush/miss event counters.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  reg_addr_t   id_rs1;
  reg_addr_t   id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  reg_addr_t   ex_rd;
  logic        ex_load_regfile;
  logic        ex_is_load;
  reg_addr_t   mem_rd;
  logic        mem_load_regfile;
  logic        imem_pend;
  logic        imem_resp;
  logic        dmem_pend;
  logic        dmem_resp;
  logic        br_mispredict;
  logic        stall_if;
  logic        bubble_ex;
  logic        flush_if_id;
  logic        hold_all;
  fwdmux_sel_t fwd_a_sel;
  fwdmux_sel_t fwd_b_sel;
  logic        wdog_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] miss_cnt;
`endif

  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cnt, flush_cnt, miss_cnt,
`endif
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_load_regfile, ex_is_load,
    output mem_rd, mem_load_regfile,
    output imem_pend, imem_resp, dmem_pend, dmem_resp,
    output br_mispredict,
    input  stall_if, bubble_ex, flush_if_id, hold_all,
    input  fwd_a_sel, fwd_b_sel, wdog_err
  );

  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output stall_cnt, flush_cnt, miss_cnt,
`endif
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_load_regfile, ex_is_load,
    input  mem_rd, mem_load_regfile,
    input  imem_pend, imem_resp, dmem_pend, dmem_resp,
    input  br_mispredict,
    output stall_if, bubble_ex, flush_if_id, hold_all,
    output fwd_a_sel, fwd_b_sel, wdog_err
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one EX operand.
// EX result beats MEM result; x0 is never forwarded.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  reg_addr_t   rs_i,
  input  reg_addr_t   ex_rd_i,
  input  logic        ex_wr_i,
  input  logic        ex_ld_i,
  input  reg_addr_t   mem_rd_i,
  input  logic        mem_wr_i,
  output fwdmux_sel_t sel_o
);

  logic nz;
  logic ex_hit;
  logic mem_hit;

  assign nz      = |rs_i;
  assign ex_hit  = nz & ex_wr_i & ~ex_ld_i & (rs_i == ex_rd_i);
  assign mem_hit = nz & mem_wr_i & (rs_i == mem_rd_i);

  always_comb begin
    if (ex_hit)       sel_o = ex_fwd;
    else if (mem_hit) sel_o = mem_fwd;
    else              sel_o = no_fwd;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID/EX hazard sequencer: load-use stall, miss freeze, flush, fwd.
// HAZARD_PERF_CNT_EN enables stall/flush/miss event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_BUBBLES = 2,
  parameter int WDOG_W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int CNT_W =
    (FLUSH_BUBBLES > 2) ? $clog2(FLUSH_BUBBLES) : 1;
  localparam logic [CNT_W-1:0] FL_LOAD =
    CNT_W'(FLUSH_BUBBLES - 1);
  localparam logic [WDOG_W-1:0] WD_MAX = '1;

  hzd_state_t        state_q, state_d;
  hzd_state_t        ret_q, ret_d;
  hzd_state_t        eff;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;

  logic miss, mp, lu;
  logic c_miss, c_mp, c_fl, c_lu;
  logic stall, bub, flush, hold;

  assign miss = (bus.imem_pend & ~bus.imem_resp)
              | (bus.dmem_pend & ~bus.dmem_resp);
  assign mp   = bus.br_mispredict | pend_q;
  assign lu   = bus.ex_is_load & bus.ex_load_regfile
              & (|bus.ex_rd)
              & ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd))
               | (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // A non-missing MEM_WAIT cycle already behaves as the resumed state.
  assign eff = (state_q == MEM_WAIT) ? ret_q : state_q;

  assign c_miss = miss;
  assign c_mp   = ~miss & mp;
  assign c_fl   = ~miss & ~mp & (eff == FLUSH);
  assign c_lu   = ~miss & ~mp & (eff == RUN) & lu;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    stall   = 1'b0;
    bub     = 1'b0;
    flush   = 1'b0;
    hold    = 1'b0;
    unique case (1'b1)
      c_miss: begin
        hold    = 1'b1;
        state_d = MEM_WAIT;
        ret_d   = eff;
        pend_d  = pend_q | bus.br_mispredict;
      end
      c_mp: begin
        flush   = 1'b1;
        bub     = 1'b1;
        pend_d  = 1'b0;
        cnt_d   = FL_LOAD;
        state_d = (FLUSH_BUBBLES > 1) ? FLUSH : RUN;
      end
      c_fl: begin
        flush   = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? RUN : FLUSH;
      end
      c_lu: begin
        stall   = 1'b1;
        bub     = 1'b1;
        state_d = LD_STALL;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wdog_d = '0;
    if (state_q == MEM_WAIT && miss)
      wdog_d = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
    err_d = err_q | (wdog_d == WD_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign bus.stall_if    = stall;
  assign bus.bubble_ex   = bub;
  assign bus.flush_if_id = flush;
  assign bus.hold_all    = hold;
  assign bus.wdog_err    = err_q;

  fwd_unit u_fwd_a (
    .rs_i     (bus.id_rs1),
    .ex_rd_i  (bus.ex_rd),
    .ex_wr_i  (bus.ex_load_regfile),
    .ex_ld_i  (bus.ex_is_load),
    .mem_rd_i (bus.mem_rd),
    .mem_wr_i (bus.mem_load_regfile),
    .sel_o    (bus.fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .rs_i     (bus.id_rs2),
    .ex_rd_i  (bus.ex_rd),
    .ex_wr_i  (bus.ex_load_regfile),
    .ex_ld_i  (bus.ex_is_load),
    .mem_rd_i (bus.mem_rd),
    .mem_wr_i (bus.mem_load_regfile),
    .sel_o    (bus.fwd_b_sel)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt_q, fcnt_q, mcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt_q <= '0;
      fcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      scnt_q <= scnt_q + {31'd0, stall};
      fcnt_q <= fcnt_q + {31'd0, c_mp};
      mcnt_q <= mcnt_q + {31'd0, hold};
    end
  end

  assign bus.stall_cnt = scnt_q;
  assign bus.flush_cnt = fcnt_q;
  assign bus.miss_cnt  = mcnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle model.
// Model tracks remaining flush cycles, pending flush and miss run length.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int FB = 2;
  localparam int WW = 4;
  localparam int WMAX = (1 << WW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .FLUSH_BUBBLES (FB),
    .WDOG_W        (WW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_flush_left;
  bit m_just_stalled;
  bit m_pend;
  int m_miss_run;
  bit m_err;
  int m_scnt, m_fcnt, m_mcnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_flush_left   = 0;
    m_just_stalled = 0;
    m_pend         = 0;
    m_miss_run     = 0;
    m_err          = 0;
    m_scnt         = 0;
    m_fcnt         = 0;
    m_mcnt         = 0;
  endtask

  function automatic logic [1:0] mfwd(int rs);
    if (rs != 0 && hif.ex_load_regfile && !hif.ex_is_load
        && rs == int'(hif.ex_rd))
      return 2'b01;
    if (rs != 0 && hif.mem_load_regfile && rs == int'(hif.mem_rd))
      return 2'b10;
    return 2'b00;
  endfunction

  task automatic idle();
    hif.id_rs1 = 0; hif.id_rs2 = 0;
    hif.id_use_rs1 = 0; hif.id_use_rs2 = 0;
    hif.ex_rd = 0; hif.ex_load_regfile = 0; hif.ex_is_load = 0;
    hif.mem_rd = 0; hif.mem_load_regfile = 0;
    hif.imem_pend = 0; hif.imem_resp = 0;
    hif.dmem_pend = 0; hif.dmem_resp = 0;
    hif.br_mispredict = 0;
  endtask

  // Compare one cycle against the model, then advance through a clock.
  task automatic cycle();
    bit miss, lu;
    bit e_st, e_bu, e_fl, e_ho;
    int n_fl, n_run;
    bit n_just, n_pend, n_err;
    #1;
    miss = (hif.imem_pend && !hif.imem_resp)
        || (hif.dmem_pend && !hif.dmem_resp);
    lu = hif.ex_is_load && hif.ex_load_regfile && hif.ex_rd != 0
      && ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd)
       || (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
    {e_st, e_bu, e_fl, e_ho} = 4'b0;
    n_fl = m_flush_left; n_just = m_just_stalled;
    n_pend = m_pend; n_run = 0;
    if (miss) begin
      e_ho = 1;
      if (hif.br_mispredict) n_pend = 1;
      n_run = m_miss_run + 1;
    end else if (hif.br_mispredict || m_pend) begin
      e_fl = 1; e_bu = 1;
      n_fl = FB - 1; n_pend = 0; n_just = 0;
    end else if (m_flush_left > 0) begin
      e_fl = 1; n_fl = m_flush_left - 1; n_just = 0;
    end else if (!m_just_stalled && lu) begin
      e_st = 1; e_bu = 1; n_just = 1;
    end else begin
      n_just = 0;
    end
    n_err = m_err || (n_run - 1 >= WMAX);
    chk("stall_if", 32'(hif.stall_if), 32'(e_st));
    chk("bubble_ex", 32'(hif.bubble_ex), 32'(e_bu));
    chk("flush_if_id", 32'(hif.flush_if_id), 32'(e_fl));
    chk("hold_all", 32'(hif.hold_all), 32'(e_ho));
    chk("fwd_a_sel", 32'(hif.fwd_a_sel), 32'(mfwd(int'(hif.id_rs1))));
    chk("fwd_b_sel", 32'(hif.fwd_b_sel), 32'(mfwd(int'(hif.id_rs2))));
    chk("wdog_err", 32'(hif.wdog_err), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", hif.stall_cnt, 32'(m_scnt));
    chk("flush_cnt", hif.flush_cnt, 32'(m_fcnt));
    chk("miss_cnt", hif.miss_cnt, 32'(m_mcnt));
`endif
    @(posedge clk);
    m_flush_left = n_fl; m_just_stalled = n_just;
    m_pend = n_pend; m_miss_run = n_run; m_err = n_err;
    m_scnt += int'(e_st);
    m_fcnt += int'(e_fl && e_bu);
    m_mcnt += int'(e_ho);
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_stall", 32'(hif.stall_if), 0);
    chk("rst_flush", 32'(hif.flush_if_id), 0);
    chk("rst_hold", 32'(hif.hold_all), 0);
    chk("rst_wdog", 32'(hif.wdog_err), 0);
    chk("rst_fwd_a", 32'(hif.fwd_a_sel), 32'(no_fwd));
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // load-use: lw x5 ; add x6,x5,x1
    hif.ex_rd = 5; hif.ex_is_load = 1; hif.ex_load_regfile = 1;
    hif.id_rs1 = 5; hif.id_use_rs1 = 1;
    hif.id_rs2 = 1; hif.id_use_rs2 = 1;
    #1;
    chk("lu_stall", 32'(hif.stall_if), 1);
    chk("lu_bubble", 32'(hif.bubble_ex), 1);
    cycle();
    hif.ex_rd = 0; hif.ex_is_load = 0; hif.ex_load_regfile = 0;
    hif.mem_rd = 5; hif.mem_load_regfile = 1;
    #1;
    chk("lu_next_stall", 32'(hif.stall_if), 0);
    chk("lu_next_fwd_a", 32'(hif.fwd_a_sel), 32'(mem_fwd));
    cycle();

    // x0 load never stalls or forwards
    idle();
    hif.ex_rd = 0; hif.ex_is_load = 1; hif.ex_load_regfile = 1;
    hif.id_rs1 = 0; hif.id_use_rs1 = 1;
    #1;
    chk("x0_stall", 32'(hif.stall_if), 0);
    chk("x0_fwd_a", 32'(hif.fwd_a_sel), 32'(no_fwd));
    cycle();

    // EX beats MEM, then MEM alone
    idle();
    hif.ex_rd = 3; hif.ex_load_regfile = 1;
    hif.mem_rd = 3; hif.mem_load_regfile = 1;
    hif.id_rs2 = 3; hif.id_use_rs2 = 1;
    #1;
    chk("fwd_b_ex", 32'(hif.fwd_b_sel), 32'(ex_fwd));
    cycle();
    hif.ex_load_regfile = 0;
    #1;
    chk("fwd_b_mem", 32'(hif.fwd_b_sel), 32'(mem_fwd));
    cycle();

    // mispredict: 2 flush cycles, bubble on the first only
    idle();
    hif.br_mispredict = 1;
    #1;
    chk("mp_flush1", 32'(hif.flush_if_id), 1);
    chk("mp_bubble1", 32'(hif.bubble_ex), 1);
    cycle();
    idle();
    #1;
    chk("mp_flush2", 32'(hif.flush_if_id), 1);
    chk("mp_bubble2", 32'(hif.bubble_ex), 0);
    cycle();
    #1;
    chk("mp_flush3", 32'(hif.flush_if_id), 0);
    cycle();

    // miss for 3 cycles with a mispredict inside the freeze
    for (int k = 1; k <= 4; k++) begin
      idle();
      hif.dmem_pend = (k <= 3);
      hif.br_mispredict = (k == 2);
      #1;
      chk("frz_hold", 32'(hif.hold_all), 32'(k <= 3));
      chk("frz_flush", 32'(hif.flush_if_id), 32'(k == 4));
      cycle();
    end
    idle();
    cycle();
    cycle();

    // pending flush is dropped by a reset pulse
    hif.dmem_pend = 1; hif.br_mispredict = 1;
    cycle();
    idle();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_drop_flush", 32'(hif.flush_if_id), 0);
    cycle();

    // watchdog: unanswered dmem request
    idle();
    hif.dmem_pend = 1;
    for (int k = 1; k <= 18; k++) begin
      #1;
      if (k == 16) chk("wdog_pre", 32'(hif.wdog_err), 0);
      if (k == 17) chk("wdog_set", 32'(hif.wdog_err), 1);
      cycle();
    end
    idle();
    #1;
    chk("wdog_sticky", 32'(hif.wdog_err), 1);
    rst = 1'b0;
    #1;
    chk("wdog_async_clr", 32'(hif.wdog_err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      hif.id_rs1 = 5'($urandom_range(0, 3));
      hif.id_rs2 = 5'($urandom_range(0, 3));
      hif.id_use_rs1 = 1'($urandom_range(0, 1));
      hif.id_use_rs2 = 1'($urandom_range(0, 1));
      hif.ex_rd = 5'($urandom_range(0, 3));
      hif.ex_load_regfile = 1'($urandom_range(0, 1));
      hif.ex_is_load = 1'($urandom_range(0, 1));
      hif.mem_rd = 5'($urandom_range(0, 3));
      hif.mem_load_regfile = 1'($urandom_range(0, 1));
      hif.imem_pend = ($urandom_range(0, 9) == 0);
      hif.imem_resp = 1'($urandom_range(0, 1));
      hif.dmem_pend = ($urandom_range(0, 9) == 0);
      hif.dmem_resp = 1'($urandom_range(0, 1));
      hif.br_mispredict = ($urandom_range(0, 11) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
